// File: rtl/nand_target_emu.sv
// Single-LUN ONFI synchronous NAND target emulator with one page buffer.
// DDR is collapsed to one byte per CLK; DOUT bytes appear one cycle after sampling.
module nand_target_emu #(
    parameter int          PAGE_BYTES   = 64,
    parameter int          COL_W        = 6,
    parameter logic [39:0] ID_BYTES     = 40'h2C884BA900,
    parameter int          READ_CYCLES  = 25,
    parameter int          PROG_CYCLES  = 200,
    parameter int          RESET_CYCLES = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CEN,
    input  logic       CLE,
    input  logic       ALE,
    input  logic       WRN,
    input  logic [7:0] DQ_IN,
    output logic [7:0] DQ_OUT,
    output logic       DQ_OE,
    output logic       DQS_OUT,
    output logic       DQS_OE,
    output logic       RBN
);

    localparam int TMR_W = 16;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DIN, S_BUSY, S_DOUT} state_e;
    typedef enum logic [1:0] {OP_ID, OP_READ, OP_PROG} op_e;
    typedef enum logic [1:0] {M_ID, M_STATUS, M_PAGE} mode_e;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    mode_e              mode_q, mode_d;
    logic               to_dout_q, to_dout_d;
    logic [2:0]         addr_cnt_q, addr_cnt_d;
    logic [7:0]         col_lo_q, col_lo_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [2:0]         idx_q, idx_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               pend_q, pend_d;
    logic [7:0]         pend_byte_q, pend_byte_d;
    logic               dq_oe_q, dq_oe_d;
    logic               dqs_q, dqs_d;
    logic [7:0]         dq_out_q, dq_out_d;
    logic [7:0]         buf_q [PAGE_BYTES];
    logic               buf_we;

    logic       is_cmd, is_addr, is_din, is_dout, rdy;
    logic [7:0] status, id_byte;

    assign is_cmd  = !CEN &&  CLE && !ALE &&  WRN;
    assign is_addr = !CEN && !CLE &&  ALE &&  WRN;
    assign is_din  = !CEN &&  CLE &&  ALE &&  WRN;
    assign is_dout = !CEN &&  CLE &&  ALE && !WRN;
    assign rdy     = (timer_q == '0);
    assign status  = {1'b1, rdy, rdy, 5'b00000};

    always_comb begin
        case (idx_q)
            3'd0:    id_byte = ID_BYTES[39:32];
            3'd1:    id_byte = ID_BYTES[31:24];
            3'd2:    id_byte = ID_BYTES[23:16];
            3'd3:    id_byte = ID_BYTES[15:8];
            3'd4:    id_byte = ID_BYTES[7:0];
            default: id_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mode_d      = mode_q;
        to_dout_d   = to_dout_q;
        addr_cnt_d  = addr_cnt_q;
        col_lo_d    = col_lo_q;
        col_d       = col_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        pend_d      = 1'b0;
        pend_byte_d = pend_byte_q;
        buf_we      = 1'b0;

        // The busy timer runs regardless of CEN or bus activity.
        if (timer_q != '0) timer_d = timer_q - TMR_W'(1);
        if (state_q == S_BUSY && timer_q == TMR_W'(1)) begin
            state_d = to_dout_q ? S_DOUT : S_IDLE;
            if (to_dout_q) mode_d = M_PAGE;
        end

        if (is_cmd) begin
            if (DQ_IN == 8'h70) begin
                mode_d = M_STATUS;
            end else if (DQ_IN == 8'hFF) begin
                state_d    = S_BUSY;
                timer_d    = TMR_W'(RESET_CYCLES);
                to_dout_d  = 1'b0;
                col_d      = '0;
                addr_cnt_d = '0;
            end else if (state_q != S_BUSY) begin
                case (DQ_IN)
                    8'h90, 8'h00, 8'h80: begin
                        state_d    = S_ADDR;
                        addr_cnt_d = '0;
                        op_d       = (DQ_IN == 8'h90) ? OP_ID :
                                     (DQ_IN == 8'h00) ? OP_READ : OP_PROG;
                    end
                    8'h30: begin
                        if (state_q == S_ADDR && op_q == OP_READ &&
                            addr_cnt_q == 3'd5) begin
                            state_d   = S_BUSY;
                            timer_d   = TMR_W'(READ_CYCLES);
                            to_dout_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                    8'h10: begin
                        if (state_q == S_DIN) begin
                            state_d   = S_BUSY;
                            timer_d   = TMR_W'(PROG_CYCLES);
                            to_dout_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end else if (is_addr && state_q == S_ADDR) begin
            if (op_q == OP_ID) begin
                state_d = S_DOUT;
                mode_d  = M_ID;
                idx_d   = '0;
            end else if (addr_cnt_q != 3'd5) begin
                addr_cnt_d = addr_cnt_q + 3'd1;
                if (addr_cnt_q == 3'd0) begin
                    col_lo_d = DQ_IN;
                    col_d    = COL_W'({8'h00, DQ_IN});
                end else if (addr_cnt_q == 3'd1) begin
                    col_d = COL_W'({DQ_IN, col_lo_q});
                end
                if (addr_cnt_q == 3'd4 && op_q == OP_PROG) state_d = S_DIN;
            end
        end else if (is_din && state_q == S_DIN) begin
            buf_we = 1'b1;
            col_d  = col_q + COL_W'(1);
        end else if (is_dout && (mode_q == M_STATUS || state_q == S_DOUT)) begin
            pend_d = 1'b1;
            case (mode_q)
                M_STATUS: pend_byte_d = status;
                M_ID: begin
                    pend_byte_d = id_byte;
                    if (idx_q != 3'd5) idx_d = idx_q + 3'd1;
                end
                default: begin
                    pend_byte_d = buf_q[col_q];
                    col_d       = col_q + COL_W'(1);
                end
            endcase
        end
    end

    always_comb begin
        dq_oe_d  = pend_q;
        dqs_d    = pend_q ? ~dqs_q : 1'b0;
        dq_out_d = pend_q ? pend_byte_q : dq_out_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            op_q        <= OP_ID;
            mode_q      <= M_PAGE;
            to_dout_q   <= 1'b0;
            addr_cnt_q  <= '0;
            col_lo_q    <= '0;
            col_q       <= '0;
            idx_q       <= '0;
            timer_q     <= '0;
            pend_q      <= 1'b0;
            pend_byte_q <= '0;
            dq_oe_q     <= 1'b0;
            dqs_q       <= 1'b0;
            dq_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mode_q      <= mode_d;
            to_dout_q   <= to_dout_d;
            addr_cnt_q  <= addr_cnt_d;
            col_lo_q    <= col_lo_d;
            col_q       <= col_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            pend_q      <= pend_d;
            pend_byte_q <= pend_byte_d;
            dq_oe_q     <= dq_oe_d;
            dqs_q       <= dqs_d;
            dq_out_q    <= dq_out_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && buf_we) buf_q[col_q] <= DQ_IN;
    end

    assign DQ_OUT  = dq_out_q;
    assign DQ_OE   = dq_oe_q;
    assign DQS_OUT = dqs_q;
    assign DQS_OE  = dq_oe_q;
    assign RBN     = rdy;

endmodule

// File: tb/tb_nand_target_emu.sv
// Directed bench for nand_target_emu: ID, program/read with wrap,
// status during busy, reset abort, CEN break in a stream, RST mid-DIN.
module tb_nand_target_emu;

    logic       CLK = 1'b0;
    logic       RST, CEN, CLE, ALE, WRN;
    logic [7:0] DQ_IN;
    logic [7:0] DQ_OUT;
    logic       DQ_OE, DQS_OUT, DQS_OE, RBN;

    int n_checks = 0;
    int n_fail   = 0;
    int low_cycles = 0;

    logic [7:0] id_exp  [6] = '{8'h2C, 8'h88, 8'h4B, 8'hA9, 8'h00, 8'h00};
    logic       dqs_exp [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    nand_target_emu dut (
        .CLK(CLK), .RST(RST), .CEN(CEN), .CLE(CLE), .ALE(ALE), .WRN(WRN),
        .DQ_IN(DQ_IN), .DQ_OUT(DQ_OUT), .DQ_OE(DQ_OE), .DQS_OUT(DQS_OUT),
        .DQS_OE(DQS_OE), .RBN(RBN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic cen, input logic cle, input logic ale,
                        input logic wrn, input logic [7:0] d);
        CEN = cen; CLE = cle; ALE = ale; WRN = wrn; DQ_IN = d;
        @(posedge CLK);
        #1;
        if (RBN === 1'b0) low_cycles++;
    endtask

    task automatic cmd(input logic [7:0] b);  step(1'b0, 1'b1, 1'b0, 1'b1, b); endtask
    task automatic addr(input logic [7:0] b); step(1'b0, 1'b0, 1'b1, 1'b1, b); endtask
    task automatic din(input logic [7:0] b);  step(1'b0, 1'b1, 1'b1, 1'b1, b); endtask
    task automatic dout();  step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00); endtask
    task automatic idle();  step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00); endtask
    task automatic desel(); step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00); endtask

    task automatic addr5(input logic [7:0] c0);
        addr(c0);
        for (int i = 0; i < 4; i++) addr(8'h00);
    endtask

    task automatic wait_ready(input int limit);
        for (int k = 0; k < limit && RBN !== 1'b1; k++) idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        idle();
        idle();
        RST = 1'b0;
        chk("rst_rbn", RBN, 1);
        chk("rst_dq_oe", DQ_OE, 0);
        chk("rst_dqs_oe", DQS_OE, 0);
        chk("rst_dq_out", DQ_OUT, 8'h00);
        chk("rst_dqs", DQS_OUT, 0);

        // READ ID
        cmd(8'h90);
        addr(8'h00);
        dout();
        for (int i = 0; i < 6; i++) begin
            if (i < 5) dout(); else idle();
            chk($sformatf("id_byte%0d", i), DQ_OUT, id_exp[i]);
            chk($sformatf("id_dqs%0d", i), DQS_OUT, dqs_exp[i]);
            chk($sformatf("id_oe%0d", i), DQ_OE, 1);
            chk($sformatf("id_rbn%0d", i), RBN, 1);
        end
        idle();
        chk("id_end_oe", DQ_OE, 0);
        chk("id_end_dqs_oe", DQS_OE, 0);
        chk("id_end_dqs", DQS_OUT, 0);

        // PROGRAM at 3E with wrap, status and ignored ADDR while busy
        cmd(8'h80);
        addr5(8'h3E);
        din(8'hDE); din(8'hAD); din(8'hBE); din(8'hEF);
        low_cycles = 0;
        cmd(8'h10);
        chk("prog_busy", RBN, 0);
        cmd(8'h70);
        dout();
        idle();
        chk("status_busy", DQ_OUT, 8'h80);
        chk("status_busy_oe", DQ_OE, 1);
        addr(8'h55);
        wait_ready(400);
        chk("prog_ready", RBN, 1);
        chk("prog_low_cycles", low_cycles, 200);
        dout();
        idle();
        chk("status_ready", DQ_OUT, 8'hE0);

        // READ back from 3E, CEN break mid-stream
        cmd(8'h00);
        addr5(8'h3E);
        low_cycles = 0;
        cmd(8'h30);
        wait_ready(100);
        chk("read_ready", RBN, 1);
        chk("read_low_cycles", low_cycles, 25);
        dout();
        dout();
        chk("page0", DQ_OUT, 8'hDE);
        chk("page0_dqs", DQS_OUT, 1);
        desel();
        chk("page1", DQ_OUT, 8'hAD);
        chk("page1_dqs", DQS_OUT, 0);
        desel();
        chk("cen_oe_drop", DQ_OE, 0);
        desel();
        chk("cen_oe_hold", DQ_OE, 0);
        chk("cen_dqs_low", DQS_OUT, 0);
        dout();
        dout();
        chk("page2_wrap", DQ_OUT, 8'hBE);
        chk("page2_dqs", DQS_OUT, 1);
        chk("page2_oe", DQ_OE, 1);
        idle();
        chk("page3_wrap", DQ_OUT, 8'hEF);
        chk("page3_dqs", DQS_OUT, 0);
        idle();
        chk("page_end_oe", DQ_OE, 0);

        // RESET during READ busy
        cmd(8'h00);
        addr5(8'h10);
        cmd(8'h30);
        for (int i = 0; i < 5; i++) idle();
        low_cycles = 0;
        cmd(8'hFF);
        wait_ready(100);
        chk("ff_ready", RBN, 1);
        chk("ff_low_cycles", low_cycles, 10);
        dout();
        idle();
        chk("ff_no_dout", DQ_OE, 0);
        cmd(8'h30);
        chk("lone30_rbn", RBN, 1);
        idle();
        chk("lone30_rbn_later", RBN, 1);

        // RST during DIN
        cmd(8'h80);
        addr5(8'h3E);
        din(8'h11);
        din(8'h22);
        RST = 1'b1;
        idle();
        RST = 1'b0;
        chk("rstdin_rbn", RBN, 1);
        chk("rstdin_oe", DQ_OE, 0);
        chk("rstdin_dq", DQ_OUT, 8'h00);
        cmd(8'h10);
        chk("rstdin_10_ignored", RBN, 1);
        idle();
        chk("rstdin_10_ignored_later", RBN, 1);

        // bytes written before RST survive
        cmd(8'h00);
        addr5(8'h3E);
        cmd(8'h30);
        wait_ready(100);
        dout();
        dout();
        chk("kept0", DQ_OUT, 8'h11);
        idle();
        chk("kept1", DQ_OUT, 8'h22);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nand_target_emu.md
Name: nand_target_emu

Overview:
- Synthesizable, single-clock emulator of one ONFI synchronous-mode NAND target (one LUN, one page buffer).
- Sits on the far end of the mkNandPhy pins in simulation and on loopback boards.
- Decodes CLE/ALE/WRN cycles from the controller, then returns ID, status and page data on DQ with a toggling DQS.
- DDR is abstracted to one byte per CLK.

Parameters:
- PAGE_BYTES, 64: page buffer depth; power of 2.
- COL_W, 6: column address width; log2(PAGE_BYTES).
- ID_BYTES, 40'h2C884B A9 00: 5-byte READ ID response, MSB byte first.
- READ_CYCLES, 25: tR busy duration in CLK.
- PROG_CYCLES, 200: tPROG busy duration in CLK.
- RESET_CYCLES, 10: tRST busy duration in CLK.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- CEN  in  1  chip enable, active low.
- CLE  in  1  command latch enable.
- ALE  in  1  address latch enable.
- WRN  in  1  W/R#: 1 = host writes, 0 = host reads.
- DQ_IN  in  8  DQ from host.
- DQ_OUT  out  8  DQ to host.
- DQ_OE  out  1  DQ output enable (tristate control in wrapper).
- DQS_OUT  out  1  data strobe to host.
- DQS_OE  out  1  DQS output enable.
- RBN  out  1  ready/busy#, open-drain semantics; 0 = busy.

Behaviour:
- Reset (RST=1 at an edge): state=IDLE, RBN=1, DQ_OE=0, DQS_OE=0, DQ_OUT=8'h00, DQS_OUT=0, column=0, addr count=0, busy timer=0. Page buffer is not reset.
- Bus decode. A cycle is sampled only when CEN=0.
  - CMD: CLE=1, ALE=0, WRN=1. Latch DQ_IN as command.
  - ADDR: CLE=0, ALE=1, WRN=1. Latch DQ_IN as address byte.
  - DIN: CLE=1, ALE=1, WRN=1. Latch DQ_IN as data byte.
  - DOUT request: CLE=1, ALE=1, WRN=0.
  - CLE=ALE=0: idle cycle; no state change.
- States: IDLE, ADDR, DIN, BUSY, DOUT.
- Commands:
  - 8'h90 READ ID: IDLE->ADDR; expects 1 address byte. Then DOUT with mode=ID, index=0.
  - 8'h70 READ STATUS: legal in any state, including BUSY. Sets mode=STATUS; outputs the status byte on every DOUT request. The underlying state is not changed (a BUSY timer keeps running).
  - 8'h00 READ: IDLE->ADDR; expects 5 address bytes.
    - Byte 0 = col[7:0], byte 1 = col[15:8]. Column = low COL_W bits of {byte1, byte0}.
    - Bytes 2-4 (row) are accepted and ignored.
    - After the 5th byte, command 8'h30 -> BUSY for READ_CYCLES, then DOUT with mode=PAGE starting at column.
  - 8'h80 PROGRAM: same 5-byte address phase, then DIN. Each DIN cycle writes buf[col] and does col=col+1 mod PAGE_BYTES (wrap, no error). Command 8'h10 -> BUSY for PROG_CYCLES, then IDLE.
  - 8'hFF RESET: legal in any state. Aborts any operation, clears column. BUSY for RESET_CYCLES, then IDLE.
  - Any other command, or a CMD cycle arriving in the wrong phase (e.g. 8'h30 without a completed address phase): ignored, state->IDLE.
  - While BUSY, only 8'h70 and 8'hFF are accepted; ADDR and DIN cycles are ignored.
- RBN: driven 0 from the cycle after the 8'h30/8'h10/8'hFF edge through the last busy cycle. Returns to 1 when the timer reaches 0.
- Status byte: {WP#=1, RDY=RBN, ARDY=RBN, 4'b0000, FAIL=0}. Value is 8'hE0 when ready, 8'h80 when busy.
- DOUT timing (fixed 1-cycle latency):
  - A DOUT request sampled at edge n drives DQ_OE=1, DQS_OE=1 and the byte on DQ_OUT after edge n+1.
  - DQS_OUT toggles with each byte: it is 1 for the first byte after entering DOUT, 0 for the second, and so on.
  - Page mode: column post-increments with wrap.
  - ID mode: index increments; indices >= 5 return 8'h00.
  - DQS_OUT returns to 0 when DQ_OE deasserts.
- DQ_OE/DQS_OE drop to 0 on the edge after the first sampled cycle that is not a DOUT request, or when CEN=1. DOUT state and the column/index are retained, so a later DOUT request resumes the stream.
- CEN=1: all inputs ignored; the busy timer keeps counting.
- RST mid-operation: immediate return to the reset values. Any program in progress is lost; buffer bytes already written remain.

Test Plan:
- RST 2 cycles, then CMD 8'h90, ADDR 8'h00, 6 DOUT requests -> DQ_OUT = 2C,88,4B,A9,00,00 one cycle later each; DQS_OUT = 1,0,1,0,1,0; RBN=1 throughout.
- PROGRAM: CMD 80, ADDR 3E,00,00,00,00, DIN DE,AD,BE,EF, CMD 10 -> RBN=0 for exactly 200 cycles. Then READ: CMD 00, ADDR 3E,00,00,00,00, CMD 30 -> RBN=0 for 25 cycles. Then 4 DOUT -> DE,AD,BE,EF. This also proves the column wrap 3F->00 (bytes are stored at 3E,3F,00,01).
- During the PROGRAM busy window: CMD 70 + DOUT -> 8'h80. After RBN rises, DOUT -> 8'hE0. An ADDR cycle sent during busy is ignored.
- CMD FF issued mid-READ busy -> RBN held 0 for 10 cycles from the FF edge, then IDLE. A subsequent CMD 30 alone is ignored (RBN stays 1).
- During a page DOUT stream: drop CEN for 3 cycles -> DQ_OE=0. Reassert CEN with DOUT -> the stream resumes at the next column.
- RST asserted during a DIN phase -> RBN=1, DQ_OE=0, state IDLE next cycle. A following CMD 10 is ignored.
